// File: rtl/dmem_responder.sv
// Fixed-latency single-port data memory responder with byte-masked writes.
// Optional build macro DMEM_RESP_ERR_EN adds an err output for conflicting or out-of-range requests.
module dmem_responder #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata
`ifdef DMEM_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            count, count_next;
  logic                  accept;
  logic                  req_err;
  logic [ADDR_BITS-1:0]  word_q;
  logic [15:0]           wdata_q;
  logic [1:0]            mask_q;
  logic                  write_q;
  logic                  err_q;
  logic                  err_hit;
  logic [15:0]           stored;
  logic [15:0]           merged;
  logic [15:0]           resp_word;
  logic [15:0]           rdata_q;
  logic [15:0]           mem [DEPTH];

  assign accept  = (state == IDLE) && (mem_read || mem_write);
  assign req_err = (mem_read && mem_write) || ((mem_address >> (ADDR_BITS + 1)) != 16'd0);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            count_next = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (count == 4'd0) state_next = RESP;
        else               count_next = count - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= 4'd0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept)         err_q   <= req_err;
      if (state == RESP)  rdata_q <= resp_word;
    end
  end

  // Request capture is pure datapath; its contents only matter once a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q  <= mem_address[ADDR_BITS:1];
      wdata_q <= mem_wdata;
      mask_q  <= mem_byte_enable;
      write_q <= mem_write;
    end
  end

`ifdef DMEM_RESP_ERR_EN
  assign err_hit = err_q;
  assign err     = mem_resp && err_q;
  logic  unused_bits;
  assign unused_bits = mem_address[0];
`else
  assign err_hit = 1'b0;
  logic  unused_bits;
  assign unused_bits = ^{mem_address[0], err_q};
`endif

  assign stored    = mem[word_q];
  assign merged    = {mask_q[1] ? wdata_q[15:8] : stored[15:8],
                      mask_q[0] ? wdata_q[7:0]  : stored[7:0]};
  assign resp_word = err_hit ? 16'h0000 : (write_q ? merged : stored);
  assign mem_resp  = (state == RESP);
  assign mem_rdata = mem_resp ? resp_word : rdata_q;

  // NOTE: storage has no reset; rst_n only blocks the commit of an aborted request.
  always_ff @(posedge clk) begin
    if (rst_n && state == RESP && write_q && !err_hit) mem[word_q] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=1,
// directed vector table, hand-written corner sequences and randomized traffic against a word-array model.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [15:0] addr  [2];
  logic [15:0] wd    [2];
  logic [1:0]  be    [2];
  logic        resp  [2];
  logic [15:0] rdata [2];
`ifdef DMEM_RESP_ERR_EN
  logic        err_o [2];
`endif

  int vectors;
  int miscompares;
  logic [15:0] model_mem [2][256];

  dmem_responder #(.LATENCY(2), .ADDR_BITS(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_wdata(wd[0]), .mem_byte_enable(be[0]),
    .mem_resp(resp[0]), .mem_rdata(rdata[0])
`ifdef DMEM_RESP_ERR_EN
    , .err(err_o[0])
`endif
  );

  dmem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_wdata(wd[1]), .mem_byte_enable(be[1]),
    .mem_resp(resp[1]), .mem_rdata(rdata[1])
`ifdef DMEM_RESP_ERR_EN
    , .err(err_o[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t table_v [11];

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: word array, byte-lane merge, alias by dropping address bits above the word index.
  function automatic void model_txn(input int u, input logic r, input logic w, input logic [15:0] a,
                                    input logic [15:0] d, input logic [1:0] m,
                                    output logic [15:0] exp_rd, output logic exp_err);
    int          word;
    logic [15:0] lane;
    word    = (int'(a) / 2) % 256;
    exp_err = 1'b0;
`ifdef DMEM_RESP_ERR_EN
    exp_err = (r && w) || (int'(a) >= 512);
`endif
    if (exp_err) begin
      exp_rd = 16'h0000;
    end else if (w) begin
      lane = (m[1] ? 16'hFF00 : 16'h0000) + (m[0] ? 16'h00FF : 16'h0000);
      model_mem[u][word] = (model_mem[u][word] & ~lane) | (d & lane);
      exp_rd = model_mem[u][word];
    end else begin
      exp_rd = model_mem[u][word];
    end
  endfunction

  task automatic drive(input int u, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    rd[u] = r; wr[u] = w; addr[u] = a; wd[u] = d; be[u] = m;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_req(input int u, input string name, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d, input logic [1:0] m,
                        input logic [15:0] exp_rd, input logic exp_err, input bit drop);
    int got_lat;
    got_lat = 0;
    drive(u, r, w, a, d, m);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      if (drop && k == 1) begin
        #1;
        drive(u, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      end
      @(negedge clk);
      if (resp[u] === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    check({name, "_latency"}, got_lat, lat_of(u));
    if (got_lat != 0) begin
      check({name, "_rdata"}, rdata[u], exp_rd);
`ifdef DMEM_RESP_ERR_EN
      check({name, "_err"}, err_o[u], exp_err);
`else
      if (exp_err) check({name, "_err_unexpected"}, 1, 0);
`endif
    end
    drive(u, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check({name, "_single_pulse"}, resp[u], 1'b0);
    check({name, "_rdata_hold"}, rdata[u], exp_rd);
  endtask

  // Model-derived transaction.
  task automatic txn(input int u, input string name, input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d, input logic [1:0] m, input bit drop);
    logic [15:0] e_rd;
    logic        e_err;
    model_txn(u, r, w, a, d, m, e_rd, e_err);
    do_req(u, name, r, w, a, d, m, e_rd, e_err, drop);
  endtask

  initial begin
    logic [15:0] e_rd;
    logic        e_err;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    for (int u = 0; u < 2; u++) drive(u, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    table_v[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'hBEEF, 1'b0};
    table_v[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
    table_v[2]  = '{1'b0, 1'b1, 16'h0012, 16'h1234, 2'b11, 16'h1234, 1'b0};
    table_v[3]  = '{1'b0, 1'b1, 16'h0012, 16'hABCD, 2'b10, 16'hAB34, 1'b0};
    table_v[4]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 2'b00, 16'hAB34, 1'b0};
    table_v[5]  = '{1'b0, 1'b1, 16'h0012, 16'h1234, 2'b11, 16'h1234, 1'b0};
    table_v[6]  = '{1'b0, 1'b1, 16'h0012, 16'hABCD, 2'b01, 16'h12CD, 1'b0};
    table_v[7]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 2'b00, 16'h12CD, 1'b0};
    table_v[8]  = '{1'b0, 1'b1, 16'h0012, 16'hFFFF, 2'b00, 16'h12CD, 1'b0};
    table_v[9]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 2'b00, 16'h12CD, 1'b0};
`ifdef DMEM_RESP_ERR_EN
    table_v[10] = '{1'b1, 1'b0, 16'h0212, 16'h0000, 2'b00, 16'h0000, 1'b1};
`else
    table_v[10] = '{1'b1, 1'b0, 16'h0212, 16'h0000, 2'b00, 16'h12CD, 1'b0};
`endif

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_resp%0d", u), resp[u], 1'b0);
      check($sformatf("reset_rdata%0d", u), rdata[u], 16'h0000);
    end

    // First request is presented together with reset release.
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 32; w++)
        txn(u, "init", 1'b0, 1'b1, 16'(w * 2), 16'($urandom), 2'b11, 1'b0);

    for (int i = 0; i < 11; i++) begin
      model_txn(0, table_v[i].rd, table_v[i].wr, table_v[i].addr, table_v[i].wdata, table_v[i].mask,
                e_rd, e_err);
      do_req(0, $sformatf("table%0d", i), table_v[i].rd, table_v[i].wr, table_v[i].addr,
             table_v[i].wdata, table_v[i].mask, table_v[i].exp_rdata, table_v[i].exp_err, 1'b0);
    end

    // Read dropped after acceptance still completes.
    txn(0, "dropped_read", 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, 1'b1);

    // Reset during BUSY aborts a write.
    drive(0, 1'b0, 1'b1, 16'h0020, 16'h5555, 2'b11);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("busy_reset_rdata", rdata[0], 16'h0000);
    for (int k = 0; k < 4; k++) begin
      check("busy_reset_no_resp", resp[0], 1'b0);
      @(negedge clk);
    end
    txn(0, "busy_reset_readback", 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, 1'b0);

    // Reset during RESP blocks the commit.
    drive(1, 1'b0, 1'b1, 16'h0022, 16'h7777, 2'b11);
    @(posedge clk);
    @(negedge clk);
    check("resp_reset_pulse", resp[1], 1'b1);
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, "resp_reset_readback", 1'b1, 1'b0, 16'h0022, 16'h0, 2'b00, 1'b0);

    // LATENCY=1 back-to-back: write then a continuously held read of the same word.
    model_txn(1, 1'b0, 1'b1, 16'h0030, 16'h0ACE, 2'b11, e_rd, e_err);
    drive(1, 1'b0, 1'b1, 16'h0030, 16'h0ACE, 2'b11);
    @(posedge clk);
    @(negedge clk);
    check("b2b_write_resp", resp[1], 1'b1);
    drive(1, 1'b1, 1'b0, 16'h0030, 16'h0, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b_resp_cycle%0d", k), resp[1], (k % 2 == 0));
      if (k % 2 == 0) begin
        model_txn(1, 1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, e_rd, e_err);
        check($sformatf("b2b_rdata_cycle%0d", k), rdata[1], e_rd);
      end
    end
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk);
    @(negedge clk);

    // Read and write together, then read back.
    txn(0, "both_set", 1'b1, 1'b1, 16'h0004, 16'h9999, 2'b11, 1'b0);
    txn(0, "both_set_readback", 1'b1, 1'b0, 16'h0004, 16'h0, 2'b00, 1'b0);

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 80; i++) begin
        int          op;
        int          hi;
        logic [15:0] a;
        op = $urandom_range(0, 2);
        hi = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 127) : 0;
        a  = 16'(hi * 512 + $urandom_range(0, 31) * 2 + $urandom_range(0, 1));
        txn(u, $sformatf("rand%0d_%0d", u, i), (op != 1), (op != 0), a, 16'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
